// File: rtl/swap_3_nums_rx_if.sv
// Stream-in / triple-out bundle for the swap-path receiver.
// A beat moves on a rising edge only when its valid and ready are both high;
// ready never depends on valid, and a source holds its payload until the beat moves.
interface swap_3_nums_rx_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             s_last;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic [WIDTH-1:0] c_out;
    logic             frame_err;
    logic [CNT_W-1:0] frame_cnt;

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, a_out, b_out, c_out, frame_err, frame_cnt
    );

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, a_out, b_out, c_out, frame_err, frame_cnt
    );
endinterface

// File: rtl/swap_3_nums_rx.sv
// Receives a forward-swapped (b,c,a) triple word by word, checks framing on s_last,
// and presents the restored a/b/c in parallel until the consumer takes them.
module swap_3_nums_rx #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    swap_3_nums_rx_if.slave       bus,
    output logic [2:0]            state_dbg
);
    typedef enum logic [2:0] {
        RX0  = 3'd0,
        RX1  = 3'd1,
        RX2  = 3'd2,
        HOLD = 3'd3,
        DROP = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] w0_q, w0_d;
    logic [WIDTH-1:0] w1_q, w1_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    // HOLD is the only state that refuses words, so ready is a pure state decode.
    assign accept = bus.s_valid && (state_q != HOLD);

    always_comb begin
        state_d = state_q;
        w0_d    = w0_q;
        w1_d    = w1_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            RX0: if (accept) begin
                if (bus.s_last) begin
                    err_d = 1'b1;
                end else begin
                    w0_d    = bus.s_data;
                    state_d = RX1;
                end
            end
            RX1: if (accept) begin
                if (bus.s_last) begin
                    err_d   = 1'b1;
                    state_d = RX0;
                end else begin
                    w1_d    = bus.s_data;
                    state_d = RX2;
                end
            end
            RX2: if (accept) begin
                if (bus.s_last) begin
                    a_d     = bus.s_data;
                    b_d     = w0_q;
                    c_d     = w1_q;
                    state_d = HOLD;
                end else begin
                    err_d   = 1'b1;
                    state_d = DROP;
                end
            end
            // Overlong frame: swallow words silently until its s_last resynchronises us.
            DROP: if (accept && bus.s_last) begin
                state_d = RX0;
            end
            HOLD: if (bus.m_ready) begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = RX0;
            end
            default: state_d = RX0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX0;
            w0_q    <= '0;
            w1_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            w0_q    <= w0_d;
            w1_q    <= w1_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.s_ready   = (state_q != HOLD);
    assign bus.m_valid   = (state_q == HOLD);
    assign bus.a_out     = a_q;
    assign bus.b_out     = b_q;
    assign bus.c_out     = c_q;
    assign bus.frame_err = err_q;
    assign bus.frame_cnt = cnt_q;
    assign state_dbg     = state_q;
endmodule

// File: tb/tb_swap_3_nums_rx.sv
// Scoreboard bench for swap_3_nums_rx: triples pushed when driven, popped on output handshake.
module tb_swap_3_nums_rx;
  localparam int W  = 8;
  localparam int CW = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  swap_3_nums_rx_if #(.WIDTH(W), .CNT_W(CW)) bus ();
  logic [2:0] state_dbg;

  swap_3_nums_rx #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // scoreboard
  logic [3*W-1:0] exp_q[$];
  logic [3*W-1:0] exp_e;
  logic [CW-1:0]  exp_cnt = '0;
  int             err_seen = 0;
  int             cyc = 0;
  int             last_hs = -1;
  bit             cnt_chk = 1'b0;
  bit             check_gap = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_cnt = '0;
      cnt_chk = 1'b0;
      last_hs = -1;
    end else begin
      if (cnt_chk) begin
        check("frame_cnt", 32'(bus.frame_cnt), 32'(exp_cnt));
        cnt_chk = 1'b0;
      end
      if (bus.frame_err) err_seen++;
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_m_valid", 32'd1, 32'd0);
        end else begin
          exp_e = exp_q.pop_front();
          check("a_out", 32'(bus.a_out), 32'(exp_e[3*W-1:2*W]));
          check("b_out", 32'(bus.b_out), 32'(exp_e[2*W-1:W]));
          check("c_out", 32'(bus.c_out), 32'(exp_e[W-1:0]));
        end
        if (check_gap && last_hs >= 0) check("triple_gap", 32'(cyc - last_hs), 32'd4);
        last_hs = cyc;
        exp_cnt = exp_cnt + 1'b1;
        cnt_chk = 1'b1;
      end
    end
  end

  // driver tasks (called between clock edges)
  task automatic send_word(input logic [W-1:0] d, input logic last);
    int n;
    n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    while (!bus.s_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.s_ready) check("s_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic send_triple(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    exp_q.push_back({a, b, c});
    send_word(b, 1'b0);
    send_word(c, 1'b0);
    send_word(a, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_valid"}, 32'(bus.m_valid), 32'd0);
    check({tag, "_s_ready"}, 32'(bus.s_ready), 32'd1);
    check({tag, "_abc"}, 32'({bus.a_out, bus.b_out, bus.c_out}), 32'd0);
    check({tag, "_frame_err"}, 32'(bus.frame_err), 32'd0);
    check({tag, "_frame_cnt"}, 32'(bus.frame_cnt), 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'd0);
  endtask

  task automatic apply_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int e0;

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b1;
    apply_reset();

    // nominal: 20,30,10 -> a=10 b=20 c=30, m_valid one cycle after last accept
    send_triple(8'd10, 8'd20, 8'd30);
    idle();
    @(negedge clk);
    check("nominal_latency_m_valid", 32'(bus.m_valid), 32'd1);
    repeat (3) @(negedge clk);

    // backpressure: outputs and s_ready=0 held while m_ready is low
    bus.m_ready = 1'b0;
    send_triple(8'd10, 8'd20, 8'd30);
    idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_m_valid", 32'(bus.m_valid), 32'd1);
      check("bp_s_ready", 32'(bus.s_ready), 32'd0);
      check("bp_abc", 32'({bus.a_out, bus.b_out, bus.c_out}), 32'h0a141e);
    end
    bus.m_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_state", 32'(state_dbg), 32'd0);
    check("bp_release_s_ready", 32'(bus.s_ready), 32'd1);
    repeat (2) @(negedge clk);

    // early last on first word
    e0 = err_seen;
    send_word(8'd20, 1'b1);
    idle();
    @(negedge clk);
    check("early_last_err", 32'(bus.frame_err), 32'd1);
    check("early_last_m_valid", 32'(bus.m_valid), 32'd0);
    @(negedge clk);
    check("early_last_err_pulse", 32'(bus.frame_err), 32'd0);
    send_triple(8'd4, 8'd5, 8'd6);
    idle();
    repeat (3) @(negedge clk);
    check("early_last_err_count", 32'(err_seen - e0), 32'd1);

    // missing last: 1,2,3 no last, then 9 with last
    e0 = err_seen;
    send_word(8'd1, 1'b0);
    send_word(8'd2, 1'b0);
    send_word(8'd3, 1'b0);
    send_word(8'd9, 1'b1);
    idle();
    repeat (3) @(negedge clk);
    check("missing_last_err_count", 32'(err_seen - e0), 32'd1);
    check("missing_last_state", 32'(state_dbg), 32'd0);
    check("missing_last_m_valid", 32'(bus.m_valid), 32'd0);
    send_triple(8'd10, 8'd20, 8'd30);
    idle();
    repeat (3) @(negedge clk);

    // reset mid-frame (asynchronous assert)
    send_word(8'd20, 1'b0);
    send_word(8'd30, 1'b0);
    idle();
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midframe_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_triple(8'd6, 8'd7, 8'd8);
    idle();
    repeat (3) @(negedge clk);

    // back-to-back with counter wrap (CNT_W=2): 1,2,3,0,1
    apply_reset();
    check_gap = 1'b1;
    for (int t = 0; t < 5; t++) begin
      send_triple(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
    end
    idle();
    repeat (3) @(negedge clk);
    check_gap = 1'b0;
    check("wrap_final_cnt", 32'(bus.frame_cnt), 32'd1);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule

// File: doc/swap_3_nums_rx.md
# swap_3_nums_rx

Byte-serial receiver and un-swapper for the three-number swap path. Accepts the forward-swapped triple as three consecutive words on a valid/ready stream, checks framing, applies the inverse rotation, and presents the restored a/b/c values in parallel behind a valid/ready output handshake. Sits downstream of the serial link that carries forward-swapped triples, and feeds any consumer expecting the original operand order.

## Interface
- WIDTH, 8, bit width of each number.
- CNT_W, 16, width of delivered-frame counter.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input word valid.
- s_ready  out  1  block can accept a word.
- s_data  in  WIDTH  input word.
- s_last  in  1  marks final (third) word of a triple.
- m_valid  out  1  restored triple valid.
- m_ready  in  1  consumer accepts triple.
- a_out, b_out, c_out  out  WIDTH each  restored numbers.
- frame_err  out  1  one-cycle pulse on framing error.
- frame_cnt  out  CNT_W  count of triples delivered.

## Operation
- Forward swap maps (a,b,c) -> (b,c,a); words arrive in order w0=b, w1=c, w2=a. Restore: a_out=w2, b_out=w0, c_out=w1.
- Word accepted when s_valid && s_ready on a rising edge.
- States: RX0, RX1, RX2, HOLD, DROP.
  - RX0: s_ready=1. Accept w0 with s_last=0 -> RX1. Accept with s_last=1 -> frame_err, discard, stay RX0.
  - RX1: s_ready=1. Accept w1 with s_last=0 -> RX2. Accept with s_last=1 -> frame_err, discard partial, -> RX0.
  - RX2: s_ready=1. Accept w2 with s_last=1 -> load a_out/b_out/c_out, -> HOLD. Accept with s_last=0 -> frame_err, discard, -> DROP.
  - DROP: s_ready=1. Discard words until one accepted with s_last=1, then -> RX0. No further frame_err while in DROP.
  - HOLD: s_ready=0, m_valid=1. On m_ready -> RX0, frame_cnt+1.
- a_out/b_out/c_out change only on entry to HOLD; stable while m_valid=1.
- frame_cnt wraps 2^CNT_W-1 -> 0. Counts only delivered triples, not errored ones.
- s_data ignored when s_valid=0 or s_ready=0; no state change.

## Timing
- Reset (async assert, any state): state RX0; m_valid=0; a_out=b_out=c_out=0; frame_err=0; frame_cnt=0; s_ready=1 (combinational from state).
- s_ready and m_valid are decoded from state only; no combinational path from s_valid or m_ready.
- Latency: m_valid rises the cycle after w2 is accepted (1 clock).
- Throughput: one triple per 4 cycles max (3 accept cycles + 1 HOLD cycle with m_ready=1); s_ready is high in the cycle after the handshake.
- Backpressure: m_ready low holds HOLD indefinitely; outputs stable; s_ready=0.
- frame_err: registered, high exactly the cycle after the offending word is accepted.
- Reset mid-frame or in HOLD: partial/pending triple discarded, no m_valid, frame_cnt cleared.
- Deassertion of rst_n is taken to be synchronous to clk externally.

## Test plan
- Nominal: stream 20,30,10 (s_last on 10), m_ready=1 -> one cycle after 10 accepted, m_valid=1, a_out=10, b_out=20, c_out=30; frame_cnt=1 after handshake.
- Backpressure: same triple with m_ready=0 for 5 cycles -> m_valid and outputs held, s_ready=0 throughout; m_ready=1 -> state RX0 next cycle, frame_cnt=1.
- Early last: 20 with s_last=1 -> frame_err pulse, no m_valid; then 5,6,4 (last on 4) -> a_out=4, b_out=5, c_out=6.
- Missing last: 1,2,3 with s_last=0 on all, then 9 with s_last=1 -> single frame_err pulse after 3, no m_valid; next 20,30,10 delivered correctly.
- Reset mid-frame: accept 20,30, assert rst_n=0 -> all outputs 0, s_ready=1; after release, 7,8,6 -> a_out=6, b_out=7, c_out=8, frame_cnt=1.
- Back-to-back and wrap: CNT_W=2, five triples with s_valid and m_ready held high -> one triple per 4 cycles, frame_cnt sequence 1,2,3,0,1.
